// File: rtl/mips_dbg_pkg.sv
// Shared definitions for the register-file dump unit.
//   dump_state_t : dump sequencer states
//   INDEX_W      : width of the beat index (register number or PC slot)
//   RF_ADDR_W    : register-file read address width
package mips_dbg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SEND   = 3'd2,
    ST_PCSEND = 3'd3,
    ST_DONE   = 3'd4
  } dump_state_t;

  localparam int INDEX_W   = 6;
  localparam int RF_ADDR_W = 5;

endpackage

// File: rtl/regfile_dump_unit_if.sv
// Dump beat stream: {index, value} beats with a valid/ready handshake.
//   out_valid : beat available (source -> sink)
//   out_ready : sink accepts beat (sink -> source)
//   out_index : register number, or NUM_REGS for the PC beat
//   out_data  : beat payload
// master = dump unit (source), slave = trace sink / monitor.
interface regfile_dump_unit_if #(
  parameter int DATA_W  = 32,
  parameter int INDEX_W = 6
);

  logic              out_valid;
  logic              out_ready;
  logic [INDEX_W-1:0] out_index;
  logic [DATA_W-1:0]  out_data;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    output out_ready
  );

endinterface

// File: rtl/halt_detector.sv
// Stable-PC halt detector.
//   clk, rst_n  : clock, async active-low reset
//   auto_en_i   : enables detection; counter held at 0 while low
//   pc_i        : CPU program counter
//   halt_o      : one-cycle pulse on the HALT_CYCLES-th consecutive cycle
//                 in which pc_i equals its value from the previous cycle
// The counter saturates above the firing value, so a PC that stays put
// fires exactly once; only a PC change (which clears the count) re-arms it.
module halt_detector #(
  parameter int DATA_W      = 32,
  parameter int HALT_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              auto_en_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic              halt_o
);

  localparam int CNT_W = $clog2(HALT_CYCLES + 1);

  logic [DATA_W-1:0] pc_prev_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_same;

  assign pc_same = (pc_i == pc_prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (!auto_en_i || !pc_same) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_W'(HALT_CYCLES)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // cnt_q counts equal cycles already completed; this cycle is the next one.
  assign halt_o = auto_en_i && pc_same && (cnt_q == CNT_W'(HALT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_prev_q <= '0;
      cnt_q     <= '0;
    end else begin
      pc_prev_q <= pc_i;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_dump_unit.sv
// End-of-run register-file dump unit for the MIPS core.
// On a start pulse or an auto-detected halt it stalls the CPU, reads the
// register file one entry per beat and streams {index, value} beats, then
// optionally a final beat carrying the PC captured at the trigger.
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle dump request (ignored while busy)
//   auto_en    : enable stable-PC halt detection
//   pc_in      : CPU program counter
//   rf_addr    : register-file read address (combinational read port)
//   rf_data    : register-file read data for rf_addr
//   cpu_stall  : freezes the CPU during the dump
//   busy       : dump in progress
//   done       : level, set after the last beat is accepted
//   dump       : beat stream (master side)
module regfile_dump_unit
  import mips_dbg_pkg::*;
#(
  parameter int NUM_REGS    = 32,
  parameter int DATA_W      = 32,
  parameter int HALT_CYCLES = 4,
  parameter int DUMP_PC     = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 auto_en,
  input  logic [DATA_W-1:0]    pc_in,
  output logic [RF_ADDR_W-1:0] rf_addr,
  input  logic [DATA_W-1:0]    rf_data,
  output logic                 cpu_stall,
  output logic                 busy,
  output logic                 done,
  regfile_dump_unit_if.master  dump
);

  localparam int                 PC_INDEX = NUM_REGS;
  localparam logic [INDEX_W-1:0] LAST_IDX = INDEX_W'(NUM_REGS - 1);

  dump_state_t        state_q;
  logic [INDEX_W-1:0] idx_q;
  logic [INDEX_W-1:0] index_q;
  logic [DATA_W-1:0]  data_q;
  logic [DATA_W-1:0]  pc_cap_q;
  logic               valid_q;
  logic               busy_q;
  logic               done_q;
  logic               halt;
  logic               trigger;
  logic               accept;

  halt_detector #(
    .DATA_W      (DATA_W),
    .HALT_CYCLES (HALT_CYCLES)
  ) u_halt_detector (
    .clk       (clk),
    .rst_n     (rst_n),
    .auto_en_i (auto_en),
    .pc_i      (pc_in),
    .halt_o    (halt)
  );

  // A simultaneous start and halt collapse into a single trigger.
  assign trigger = start || halt;
  assign accept  = valid_q && dump.out_ready;

  assign rf_addr        = idx_q[RF_ADDR_W-1:0];
  assign cpu_stall      = busy_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign dump.out_valid = valid_q;
  assign dump.out_index = index_q;
  assign dump.out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      index_q  <= '0;
      data_q   <= '0;
      pc_cap_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (trigger) begin
            pc_cap_q <= pc_in;
            idx_q    <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b1;
            state_q  <= ST_READ;
          end
        end

        ST_READ: begin
          data_q  <= rf_data;
          index_q <= idx_q;
          valid_q <= 1'b1;
          state_q <= ST_SEND;
        end

        ST_SEND: begin
          if (accept) begin
            valid_q <= 1'b0;
            if (idx_q < LAST_IDX) begin
              idx_q   <= idx_q + INDEX_W'(1);
              state_q <= ST_READ;
            end else if (DUMP_PC != 0) begin
              // PC beat is loaded directly; no read cycle is needed for it.
              data_q  <= pc_cap_q;
              index_q <= INDEX_W'(PC_INDEX);
              valid_q <= 1'b1;
              state_q <= ST_PCSEND;
            end else begin
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end

        ST_PCSEND: begin
          if (accept) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end
        end

        default: begin
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
